// File: rtl/mont_conv_div.sv
`default_nettype none
// ============================================================================
//  Module      : mont_conv_div
//  Description : Bit-serial restoring reducer that maps an operand into the
//                Montgomery domain: result = (num_in * 2^len) mod modulus.
//                One quotient bit per clock, fixed latency WIDTH + len cycles,
//                start/busy/done handshake, zero-modulus error flag.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module mont_conv_div #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 8,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] num_in,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   // Operand bits are fed MSB first out of sh; after the WIDTH operand bits
   // the zero fill supplies the len extra doublings that form the 2^len factor.
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] rem;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff_lo;
   logic             fits;
   logic [WIDTH-1:0] rem_nxt;

   logic             accept;
   logic             mod_zero;
   logic             last_step;

   // Handshake qualifiers: a start is only honoured while idle.
   always_comb begin
      accept    = (state == IDLE) && start;
      mod_zero  = (modulus == '0);
      last_step = (state == RUN) && (cnt == CNT_W'(1));
   end

   // One restoring step: shift the next operand bit into the remainder and
   // subtract the modulus if it fits. Because rem < m is invariant, trial is
   // below 2m, so a single conditional subtract is enough and the difference
   // always fits in WIDTH bits (its low WIDTH bits are the exact answer).
   always_comb begin
      trial   = {rem, sh[WIDTH-1]};
      fits    = (trial >= {1'b0, m});
      diff_lo = trial[WIDTH-1:0] - m;
      rem_nxt = fits ? diff_lo : trial[WIDTH-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: a zero modulus completes inside IDLE without running.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && !mod_zero) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_step) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and handshake outputs: operands are captured only at the
   // accepting edge so later input changes cannot disturb a run in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh     <= '0;
         m      <= '0;
         rem    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            sh  <= num_in;
            m   <= modulus;
            rem <= '0;
            cnt <= CNT_W'(WIDTH) + CNT_W'(len);
            err <= mod_zero;
            if (mod_zero) begin
               done   <= 1'b1;
               result <= '0;
            end else begin
               busy <= 1'b1;
            end
         end else if (state == RUN) begin
            sh  <= {sh[WIDTH-2:0], 1'b0};
            rem <= rem_nxt;
            cnt <= cnt - CNT_W'(1);
            if (last_step) begin
               result <= rem_nxt;
               done   <= 1'b1;
               busy   <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mont_conv_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mont_conv_div
//  Description : Self-checking bench for mont_conv_div (WIDTH=32): an
//                arithmetic reference model compared every cycle, plus
//                directed operations with hand-computed results/latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mont_conv_div;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [7:0]  len;
   logic [31:0] num_in;
   logic [31:0] modulus;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   mont_conv_div #(.WIDTH(32), .LEN_W(8), .CNT_W(10)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
      .len     (len),
      .num_in  (num_in),
      .modulus (modulus),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: (n * 2^l) mod m by repeated modular doubling.
   function automatic logic [31:0] mont_ref(input logic [31:0] n, input int l, input logic [31:0] m);
      longint unsigned r;
      r = longint'(n) % longint'(m);
      for (int i = 0; i < l; i++) begin
         r = (r * 2) % longint'(m);
      end
      return r[31:0];
   endfunction

   // Behavioural model: what the outputs must be after each edge.
   logic        mb = 1'b0;
   logic        md = 1'b0;
   logic        me = 1'b0;
   logic [31:0] mr = '0;
   logic [31:0] pend = '0;
   int          left = 0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mb = 1'b0; md = 1'b0; me = 1'b0; mr = '0; left = 0;
      end else begin
         md = 1'b0;
         if (mb) begin
            left--;
            if (left == 0) begin
               mb = 1'b0; md = 1'b1; mr = pend;
            end
         end else if (start) begin
            me = 1'b0;
            if (modulus == 32'd0) begin
               md = 1'b1; me = 1'b1; mr = '0;
            end else begin
               mb   = 1'b1;
               left = 32 + int'(len);
               pend = mont_ref(num_in, int'(len), modulus);
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      check("busy", {31'd0, busy}, {31'd0, mb});
      check("done", {31'd0, done}, {31'd0, md});
      check("err", {31'd0, err}, {31'd0, me});
      check("result", result, mr);
   end

   task automatic launch(input logic [31:0] n, input logic [7:0] l, input logic [31:0] m);
      num_in = n; len = l; modulus = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; lat counts negedges from the accepting edge.
   task automatic wait_done(input string name, input logic [31:0] exp_r, input logic exp_e, input int exp_lat);
      int lat;
      lat = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         total++; bad++;
         $display("FAIL %s timeout: no done within 400 cycles", name);
      end else begin
         check({name, "_lat"}, lat, exp_lat);
         check({name, "_res"}, result, exp_r);
         check({name, "_err"}, {31'd0, err}, {31'd0, exp_e});
      end
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; len = '0; num_in = '0; modulus = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_res", result, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // 5*8 mod 7 = 5, N = 35
      launch(32'd5, 8'd3, 32'd7);
      wait_done("basic", 32'd5, 1'b0, 36);
      @(posedge clk); #1;

      // plain reduction 100 mod 7 = 2, N = 32
      launch(32'd100, 8'd0, 32'd7);
      wait_done("len0", 32'd2, 1'b0, 33);
      @(posedge clk); #1;

      // (2^32-1)*2^32 mod (2^32-5) = 4*5 = 20
      launch(32'hFFFF_FFFF, 8'd32, 32'hFFFF_FFFB);
      wait_done("big", 32'h14, 1'b0, 65);
      @(posedge clk); #1;

      // operand above modulus: 50*4 mod 13 = 5
      launch(32'd50, 8'd2, 32'd13);
      wait_done("ovr", 32'd5, 1'b0, 35);
      @(posedge clk); #1;

      // zero modulus flags err immediately, busy never rises
      launch(32'd9, 8'd4, 32'd0);
      wait_done("modzero", 32'd0, 1'b1, 1);
      @(posedge clk); #1;

      // next valid start clears err: 10*2 mod 7 = 6
      launch(32'd10, 8'd1, 32'd7);
      wait_done("errclr", 32'd6, 1'b0, 34);
      @(posedge clk); #1;

      // modulus 1 always yields 0
      launch(32'hDEAD_BEEF, 8'd17, 32'd1);
      wait_done("mod1", 32'd0, 1'b0, 50);
      @(posedge clk); #1;

      // ignored start and input changes mid-run; original result survives
      launch(32'd5, 8'd3, 32'd7);
      repeat (10) begin
         @(posedge clk); #1;
      end
      num_in = 32'd1000; len = 8'd5; modulus = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; modulus = 32'd99;
      wait_done("ignore", 32'd5, 1'b0, 25);
      // back-to-back: start on the done cycle, 7*16 mod 10 = 2, N = 36
      launch(32'd7, 8'd4, 32'd10);
      wait_done("b2b", 32'd2, 1'b0, 37);
      @(posedge clk); #1;

      // reset halfway through a long run aborts it without done
      launch(32'h1234_5678, 8'd200, 32'hFFFF_FFFB);
      repeat (100) begin
         @(posedge clk); #1;
      end
      rstn = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_res", result, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // fresh run after reset: 3*32 mod 11 = 8
      launch(32'd3, 8'd5, 32'd11);
      wait_done("postrst", 32'd8, 1'b0, 38);
      @(posedge clk); #1;
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mont_conv_div.md
Name: mont_conv_div

Overview:
- Parametrised successor to the fixed 32-bit long-division converter in the RSA datapath.
- Computes result = (num_in * 2^len) mod modulus, i.e. it maps an operand into the Montgomery domain with R = 2^len.
- Uses a bit-serial restoring shift/subtract reducer with a clean start/busy/done handshake, explicit zero-modulus error, a fixed and predictable latency, and no 2*WIDTH multiplier.
- Sits in front of the Montgomery multiplier and exponentiation controller.

Parameters:
- WIDTH, 32, operand/modulus/result width in bits (>= 2).
- LEN_W, 8, width of the len input; the shift amount ranges over 0 .. 2^LEN_W-1.
- CNT_W, 10, step-counter width; must satisfy 2^CNT_W > WIDTH + 2^LEN_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- len  input  LEN_W  exponent of R (R = 2^len).
- num_in  input  WIDTH  operand; any value is allowed, including values >= modulus.
- modulus  input  WIDTH  modulus; 0 is illegal and flagged.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when result/err are valid.
- err  output  1  set with done when modulus == 0; cleared on the next accepted start.
- result  output  WIDTH  (num_in * 2^len) mod modulus; held until the next done.

Behaviour:
- Reset (async, rstn=0): busy=0, done=0, err=0, result=0, state=IDLE, internal rem/shift/count registers=0. Reset mid-conversion aborts it; no done is produced.
- States: IDLE, RUN.
- IDLE, start=1 at edge T0:
  - Latch num_in into shift register sh, modulus into m, len; set rem=0 and cnt = WIDTH + len; set err=0.
  - If modulus == 0: stay in IDLE; at the same edge assert done=1, err=1, result=0. busy stays 0.
  - Otherwise go to RUN with busy=1.
- RUN, each edge:
  - b = sh[WIDTH-1]; sh <= sh << 1 with zero fill.
  - t = {rem, b}, WIDTH+1 bits wide.
  - rem <= (t >= {1'b0, m}) ? t - m : t. One conditional subtract suffices because rem < m always holds.
  - cnt <= cnt - 1.
- Completion: on the RUN edge where cnt == 1:
  - Write the final rem to result; pulse done=1; set busy=0; go to IDLE.
- Latency: done is high in the cycle following edge T0 + N, where N = WIDTH + len. busy is high for exactly N cycles.
- done is a single-cycle pulse, deasserted automatically on the next edge.
- result and err hold until the next done.
- start while busy=1 is ignored; no queueing.
- start in the same cycle that done is high is accepted, giving back-to-back operation.
- Inputs are sampled only at the accepting edge; later changes to num_in/modulus/len do not affect an operation in flight.
- len = 0 is plain reduction: N = WIDTH.
- modulus = 1 always yields 0.
- Arithmetic: the compare/subtract is WIDTH+1 bits wide; result is always < modulus.

Test Plan:
- WIDTH=32: num_in=5, len=3, modulus=7, single start -> busy high 35 cycles, then done pulse with result=5 (40 mod 7), err=0.
- num_in=100, len=0, modulus=7 -> result=2 after 32 cycles; num_in=0xFFFFFFFF, len=32, modulus=0xFFFFFFFB -> result=0x14 after 64 cycles.
- modulus=0, num_in=9, len=4 -> done on the cycle after start with err=1, result=0, busy never high; next valid start clears err.
- During busy, pulse start with different operands -> ignored, original result delivered; start issued on the done cycle -> second result follows exactly N cycles later.
- Change num_in/modulus mid-operation -> result unaffected; modulus=1, any num_in/len -> result=0.
- Assert rstn=0 halfway through a len=200 run -> outputs immediately 0, no done; a new start after release computes correctly.
